// File: rtl/cache_arbiter.sv
// Arbitrates the shared memory line port between I-cache and D-cache.
// Ports: i_* I-cache side, d_* D-cache side, m_* memory side, clk/rst.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LINE_WIDTH-1:0] m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  input  logic                  m_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t state, state_n;

  // 0 = I-cache won last, 1 = D-cache won last
  logic                  last_grant;
  logic                  cmd_read;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LINE_WIDTH-1:0] cmd_wdata;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Command outputs come only from registers; m_resp never reaches them.
  assign m_read  = cmd_read  & (state != IDLE);
  assign m_write = cmd_write & (state != IDLE);
  assign m_addr  = cmd_addr;
  assign m_wdata = cmd_wdata;

  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    unique case (state)
      IDLE: begin
        // On conflict the side that lost last time wins.
        if (i_req && d_req) begin
          grant_i = last_grant;
          grant_d = ~last_grant;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i) state_n = SERVE_I;
        if (grant_d) state_n = SERVE_D;
      end
      SERVE_I: begin
        if (m_resp) begin
          i_resp  = ~rst;
          state_n = IDLE;
        end
      end
      SERVE_D: begin
        if (m_resp) begin
          d_resp  = ~rst;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      state <= state_n;
      if (grant_i) begin
        last_grant <= 1'b0;
        cmd_read   <= 1'b1;
        cmd_write  <= 1'b0;
        cmd_addr   <= i_addr;
      end
      if (grant_d) begin
        last_grant <= 1'b1;
        // A writeback takes priority over a simultaneous read.
        cmd_read   <= d_read & ~d_write;
        cmd_write  <= d_write;
        cmd_addr   <= d_addr;
        cmd_wdata  <= d_wdata;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $error("cache_arbiter: d_read and d_write both high");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table
// followed by randomized requesters against a transaction model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          m_read;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_rdata;
  logic          m_resp;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_read (i_read),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_resp (i_resp),
    .d_read (d_read),
    .d_write(d_write),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_resp (d_resp),
    .m_read (m_read),
    .m_write(m_write),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_resp (m_resp)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [LW-1:0] dwd;
    logic          mr;
    logic [LW-1:0] mrd;
    logic          er;
    logic          ew;
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd;
    logic          eir;
    logic          edr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic rs, input logic ir, input logic [AW-1:0] ia,
    input logic dr, input logic dw, input logic [AW-1:0] da,
    input logic [LW-1:0] dwd, input logic mr, input logic [LW-1:0] mrd,
    input logic er, input logic ew, input logic [AW-1:0] ea,
    input logic [LW-1:0] ewd, input logic eir, input logic edr);
    vec_t v;
    v.rst = rs; v.ir = ir; v.ia = ia;
    v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.mr = mr; v.mrd = mrd;
    v.er = er; v.ew = ew; v.ea = ea; v.ewd = ewd;
    v.eir = eir; v.edr = edr;
    tbl.push_back(v);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // randomized-phase state
  logic          s_ir, s_dr, cmd_seen;
  int            lat;
  int            owner;
  int            last_won;
  int            c_op;
  logic [AW-1:0] c_addr;
  logic [LW-1:0] c_wd;

  initial begin
    logic [LW-1:0] aa, w1, rd2, rd3;
    logic [AW-1:0] z;
    aa  = {32{8'hAA}};
    w1  = {8{32'h12345678}};
    rd2 = {8{32'hC0FFEE00}};
    rd3 = {8{32'h5A5A0F0F}};
    z   = '0;

    rst = 1'b1; i_read = 0; i_addr = 0;
    d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    m_rdata = 0; m_resp = 0;

    //   rst ir ia  dr dw da  dwd mr mrd  er ew ea  ewd eir edr
    add(1, 0, z,    0, 0, z,     0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 1, 'h60, 0, 0, z,     0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 1, 'h60, 0, 0, z,     0, 0, 0,   1, 0, 'h60, 0, 0, 0);
    add(0, 1, 'h60, 0, 0, z,     0, 1, aa,  1, 0, 'h60, 0, 1, 0);
    add(0, 0, z,    0, 0, z,     0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 0, z,    0, 1, 'h100, w1, 0, 0,  0, 0, z,    0, 0, 0);
    add(0, 0, z,    0, 1, 'h200, w1, 0, 0,  0, 1, 'h100, w1, 0, 0);
    add(0, 0, z,    0, 1, 'h200, w1, 1, 0,  0, 1, 'h100, w1, 0, 1);
    add(0, 0, z,    0, 0, z,     0, 1, rd3, 0, 0, z,    0, 0, 0);
    add(0, 0, z,    0, 0, z,     0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 1, 'h40, 1, 0, 'h80,  0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 1, 'h40, 1, 0, 'h80,  0, 0, 0,   1, 0, 'h40, 0, 0, 0);
    add(0, 1, 'h40, 1, 0, 'h80,  0, 1, rd2, 1, 0, 'h40, 0, 1, 0);
    add(0, 0, z,    1, 0, 'h80,  0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 0, z,    1, 0, 'h80,  0, 0, 0,   1, 0, 'h80, 0, 0, 0);
    add(1, 0, z,    1, 0, 'h80,  0, 1, rd3, 1, 0, 'h80, 0, 0, 0);
    add(0, 0, z,    0, 0, z,     0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 1, 'h40, 1, 0, 'h80,  0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 1, 'h40, 1, 0, 'h80,  0, 0, 0,   1, 0, 'h80, 0, 0, 0);
    add(0, 1, 'h40, 1, 0, 'h80,  0, 1, rd2, 1, 0, 'h80, 0, 0, 1);
    add(0, 1, 'h40, 0, 0, z,     0, 0, 0,   0, 0, z,    0, 0, 0);
    add(0, 1, 'h40, 0, 0, z,     0, 1, aa,  1, 0, 'h40, 0, 1, 0);
    add(0, 0, z,    0, 0, z,     0, 0, 0,   0, 0, z,    0, 0, 0);

    repeat (2) @(posedge clk);

    foreach (tbl[n]) begin
      @(posedge clk);
      #1;
      rst = tbl[n].rst;
      i_read = tbl[n].ir; i_addr = tbl[n].ia;
      d_read = tbl[n].dr; d_write = tbl[n].dw;
      d_addr = tbl[n].da; d_wdata = tbl[n].dwd;
      m_resp = tbl[n].mr; m_rdata = tbl[n].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d m_read", n), LW'(m_read), LW'(tbl[n].er));
      chk($sformatf("vec%0d m_write", n), LW'(m_write), LW'(tbl[n].ew));
      chk($sformatf("vec%0d i_resp", n), LW'(i_resp), LW'(tbl[n].eir));
      chk($sformatf("vec%0d d_resp", n), LW'(d_resp), LW'(tbl[n].edr));
      if (tbl[n].er || tbl[n].ew)
        chk($sformatf("vec%0d m_addr", n), LW'(m_addr), LW'(tbl[n].ea));
      if (tbl[n].ew)
        chk($sformatf("vec%0d m_wdata", n), m_wdata, tbl[n].ewd);
      if (tbl[n].eir)
        chk($sformatf("vec%0d i_rdata", n), i_rdata, tbl[n].mrd);
      if (tbl[n].edr)
        chk($sformatf("vec%0d d_rdata", n), d_rdata, tbl[n].mrd);
    end

    // randomized phase
    @(posedge clk);
    #1;
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; m_resp = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_ir = 0; s_dr = 0; cmd_seen = 0; lat = -1;
    owner = 0; last_won = 1; c_op = 0; c_addr = 0; c_wd = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      // I-cache agent
      if (s_ir) i_read = 0;
      else if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1;
        i_addr = $urandom & ~32'h1F;
      end else if (i_read && $urandom_range(0, 7) == 0)
        i_addr = $urandom & ~32'h1F;
      // D-cache agent
      if (s_dr) begin
        d_read = 0; d_write = 0;
      end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        d_write = 1'($urandom_range(0, 1));
        d_read = ~d_write;
        d_addr = $urandom & ~32'h1F;
        d_wdata = rnd_line();
      end else if ((d_read || d_write) && $urandom_range(0, 7) == 0) begin
        d_addr = $urandom & ~32'h1F;
        d_wdata = rnd_line();
      end
      // memory
      m_rdata = rnd_line();
      if (m_resp) begin
        m_resp = 0;
        lat = -1;
      end else if (cmd_seen) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) m_resp = 1;
        else lat--;
      end else if ($urandom_range(0, 19) == 0) begin
        m_resp = 1;
      end

      @(negedge clk);
      chk("rnd m_read", LW'(m_read), LW'(owner != 0 && c_op == 0));
      chk("rnd m_write", LW'(m_write), LW'(owner != 0 && c_op == 1));
      chk("rnd i_resp", LW'(i_resp), LW'(owner == 1 && m_resp));
      chk("rnd d_resp", LW'(d_resp), LW'(owner == 2 && m_resp));
      if (owner != 0) chk("rnd m_addr", LW'(m_addr), LW'(c_addr));
      if (owner != 0 && c_op == 1) chk("rnd m_wdata", m_wdata, c_wd);
      if (owner == 1 && m_resp) chk("rnd i_rdata", i_rdata, m_rdata);
      if (owner == 2 && m_resp) chk("rnd d_rdata", d_rdata, m_rdata);

      // model: one transaction at a time, alternate on conflict
      if (owner != 0) begin
        if (m_resp) owner = 0;
      end else begin
        int want_i, want_d, win;
        want_i = i_read ? 1 : 0;
        want_d = (d_read || d_write) ? 1 : 0;
        if (want_i + want_d == 2) win = 3 - last_won;
        else if (want_i == 1) win = 1;
        else if (want_d == 1) win = 2;
        else win = 0;
        if (win == 1) begin
          c_op = 0; c_addr = i_addr;
        end else if (win == 2) begin
          c_op = d_write ? 1 : 0; c_addr = d_addr; c_wd = d_wdata;
        end
        if (win != 0) begin
          owner = win;
          last_won = win;
        end
      end

      s_ir = i_resp;
      s_dr = d_resp;
      cmd_seen = m_read | m_write;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
